// File: rtl/fixed_point_unit_seq.sv
// rtl/fixed_point_unit_seq.sv - handshaked iterative signed fixed-point unit (ADD/SUB/MUL/DIV/SQRT)
module fixed_point_unit_seq #(
    parameter int WIDTH    = 32,
    parameter int FBITS    = 10,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             overflow,
    output logic             invalid
);
    // DW: width of the scaled dividend / radicand; SW: width of the square root
    localparam int DW = WIDTH + FBITS;
    localparam int SW = DW / 2;
    localparam int RW = SW + 2;
    localparam int CW = $clog2(DW + 1);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] MUL_ITERS  = CW'(WIDTH);
    localparam logic [CW-1:0] MUL_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] DIV_ITERS  = CW'(DW);
    localparam logic [CW-1:0] SQRT_ITERS = CW'(SW);

    localparam logic [WIDTH-1:0]   MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   MAX_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] MUL_HALF = {{(2*WIDTH-1){1'b0}}, 1'b1} << (FBITS - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_DIV,
        S_SQRT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    logic [DW-1:0]      r_div_num;
    logic [DW-1:0]      r_quo;
    logic [WIDTH-1:0]   r_div_d;
    logic [WIDTH-1:0]   r_div_rem;

    logic [DW-1:0]      r_sq_rad;
    logic [RW-1:0]      r_sq_rem;
    logic [SW-1:0]      r_root;

    logic [WIDTH-1:0]   r_result;
    logic               r_ovf;
    logic               r_inv;

    logic               w_accept;
    logic               w_iter_done;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    logic [WIDTH:0]     w_sum;
    logic               w_add_ovf;

    logic [2*WIDTH-1:0] w_mul_rnd;
    logic [WIDTH-FBITS:0] w_mul_hi;
    logic               w_mul_ovf;

    logic [WIDTH:0]     w_div_trial;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic               w_div_neg;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_q_low;
    logic               w_div_ovf;
    logic [WIDTH-1:0]   w_div_wrap;

    logic [RW-1:0]      w_sq_cat;
    logic [RW-1:0]      w_sq_trial;
    logic [RW-1:0]      w_sq_diff;
    logic               w_sq_ge;

    logic               w_unused;

    // Clamp to the signed range when saturating, otherwise pass the wrapped value
    function automatic logic [WIDTH-1:0] f_clamp(input logic ovf, input logic neg,
                                                 input logic [WIDTH-1:0] wrapped);
        if (ovf && SATURATE) begin
            return neg ? MAX_NEG : MAX_POS;
        end
        return wrapped;
    endfunction

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign ready    = (r_state == S_DONE);
    assign result   = r_result;
    assign overflow = r_ovf;
    assign invalid  = r_inv;

    assign w_accept = start && !busy;
    assign w_abs_a  = operand_1[WIDTH-1] ? -operand_1 : operand_1;
    assign w_abs_b  = operand_2[WIDTH-1] ? -operand_2 : operand_2;

    // ADD/SUB one bit wider than the operands so the carry into the sign is visible
    assign w_sum     = (r_op == OP_SUB) ? ({r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b})
                                        : ({r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b});
    assign w_add_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    // MUL: round half-up, then everything above the taken field must be sign extension
    assign w_mul_rnd = r_acc + MUL_HALF;
    assign w_mul_hi  = w_mul_rnd[2*WIDTH-1:WIDTH+FBITS-1];
    assign w_mul_ovf = !((&w_mul_hi) || !(|w_mul_hi));

    // DIV: one restoring step per cycle on magnitudes
    assign w_div_trial = {r_div_rem, r_div_num[DW-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_div_d});
    assign w_div_diff  = w_div_trial - {1'b0, r_div_d};
    assign w_div_neg   = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_div_zero  = ~|r_b;
    assign w_q_low     = r_quo[WIDTH-1:0];
    // a negative quotient may reach exactly 2^(WIDTH-1), a positive one may not
    assign w_div_ovf   = (|r_quo[DW-1:WIDTH]) ||
                         (w_div_neg ? (w_q_low[WIDTH-1] && (|w_q_low[WIDTH-2:0]))
                                    : w_q_low[WIDTH-1]);
    assign w_div_wrap  = w_div_neg ? -w_q_low : w_q_low;

    // SQRT: bring down the next bit pair and try subtracting (root<<2)|1
    assign w_sq_cat   = {r_sq_rem[RW-3:0], r_sq_rad[DW-1:DW-2]};
    assign w_sq_trial = {r_root, 2'b01};
    assign w_sq_ge    = (w_sq_cat >= w_sq_trial);
    assign w_sq_diff  = w_sq_cat - w_sq_trial;

    // Bits that are provably zero or discarded by design
    assign w_unused = ^{r_sq_rem[RW-1:RW-2], w_div_diff[WIDTH], w_mul_rnd[FBITS-1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: dispatch on accept, leave an iterative state once its count is reached
    always_comb begin
        w_next_state = r_state;
        w_iter_done  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next_state = S_IDLE;
                if (start) begin
                    case (operation)
                        OP_MUL:  w_next_state = S_MUL;
                        OP_DIV:  w_next_state = S_DIV;
                        OP_SQRT: w_next_state = S_SQRT;
                        default: w_next_state = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB: w_next_state = S_DONE;
            S_MUL: begin
                w_iter_done = (r_cnt == MUL_ITERS);
                if (w_iter_done) w_next_state = S_DONE;
            end
            S_DIV: begin
                w_iter_done = (r_cnt == DIV_ITERS);
                if (w_iter_done) w_next_state = S_DONE;
            end
            S_SQRT: begin
                w_iter_done = (r_cnt == SQRT_ITERS);
                if (w_iter_done) w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: latch and seed iterators on accept, iterate, then commit result and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= 3'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_div_num <= '0;
            r_quo     <= '0;
            r_div_d   <= '0;
            r_div_rem <= '0;
            r_sq_rad  <= '0;
            r_sq_rem  <= '0;
            r_root    <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_inv     <= 1'b0;
        end else if (w_accept) begin
            r_op      <= operation;
            r_a       <= operand_1;
            r_b       <= operand_2;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{operand_1[WIDTH-1]}}, operand_1};
            r_mplier  <= operand_2;
            r_div_num <= {w_abs_a, {FBITS{1'b0}}};
            r_quo     <= '0;
            r_div_d   <= w_abs_b;
            r_div_rem <= '0;
            r_sq_rad  <= {operand_1, {FBITS{1'b0}}};
            r_sq_rem  <= '0;
            r_root    <= '0;
            r_ovf     <= 1'b0;
            r_inv     <= 1'b0;
        end else begin
            case (r_state)
                S_ADDSUB: begin
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_result <= f_clamp(w_add_ovf, w_sum[WIDTH], w_sum[WIDTH-1:0]);
                        r_ovf    <= w_add_ovf;
                    end else begin
                        r_result <= '0;
                        r_inv    <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (!w_iter_done) begin
                        // the multiplier MSB carries negative weight in two's complement
                        if (r_mplier[0]) begin
                            r_acc <= (r_cnt == MUL_LAST) ? (r_acc - r_mcand) : (r_acc + r_mcand);
                        end
                        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        r_cnt    <= r_cnt + CNT_ONE;
                    end else begin
                        r_result <= f_clamp(w_mul_ovf, w_mul_rnd[2*WIDTH-1],
                                            w_mul_rnd[WIDTH+FBITS-1:FBITS]);
                        r_ovf    <= w_mul_ovf;
                    end
                end
                S_DIV: begin
                    if (!w_iter_done) begin
                        r_div_rem <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
                        r_quo     <= {r_quo[DW-2:0], w_div_ge};
                        r_div_num <= {r_div_num[DW-2:0], 1'b0};
                        r_cnt     <= r_cnt + CNT_ONE;
                    end else if (w_div_zero) begin
                        r_result <= r_a[WIDTH-1] ? MAX_NEG : MAX_POS;
                        r_inv    <= 1'b1;
                    end else begin
                        r_result <= f_clamp(w_div_ovf, w_div_neg, w_div_wrap);
                        r_ovf    <= w_div_ovf;
                    end
                end
                S_SQRT: begin
                    if (!w_iter_done) begin
                        r_sq_rem <= w_sq_ge ? w_sq_diff : w_sq_cat;
                        r_root   <= {r_root[SW-2:0], w_sq_ge};
                        r_sq_rad <= {r_sq_rad[DW-3:0], 2'b00};
                        r_cnt    <= r_cnt + CNT_ONE;
                    end else if (r_a[WIDTH-1]) begin
                        r_result <= '0;
                        r_inv    <= 1'b1;
                    end else begin
                        r_result <= {{(WIDTH-SW){1'b0}}, r_root};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_unit_seq.sv
// tb/tb_fixed_point_unit_seq.sv - directed self-checking bench for fixed_point_unit_seq
module tb_fixed_point_unit_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   operation;
    logic [W-1:0] operand_1;
    logic [W-1:0] operand_2;
    logic         busy, ready, overflow, invalid;
    logic [W-1:0] result;
    logic         wr_busy, wr_ready, wr_overflow, wr_invalid;
    logic [W-1:0] wr_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2), .busy(busy), .result(result),
        .ready(ready), .overflow(overflow), .invalid(invalid)
    );

    fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2), .busy(wr_busy), .result(wr_result),
        .ready(wr_ready), .overflow(wr_overflow), .invalid(wr_invalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op, then check busy/flag clear, latency, result and flags
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] exp_r,
                          input logic exp_o, input logic exp_i);
        int cyc;
        @(negedge clk);
        start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_accept"}, busy, 1);
        chk({tag, " flags_cleared"}, {overflow, invalid}, 0);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " result"}, result, exp_r);
        chk({tag, " overflow"}, overflow, exp_o);
        chk({tag, " invalid"}, invalid, exp_i);
        chk({tag, " busy_in_done"}, busy, 0);
    endtask

    initial begin
        int  cyc;
        logic seen_ready;
        reset = 1'b0; start = 1'b0; operation = 3'd0; operand_1 = '0; operand_2 = '0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset ready", ready, 0);
        chk("reset result", result, 0);
        chk("reset flags", {overflow, invalid}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op("add", 3'd0, 32'h0000_0600, 32'h0000_0800, 1, 32'h0000_0E00, 0, 0);
        run_op("sub", 3'd1, 32'h0000_0600, 32'h0000_0800, 1, 32'hFFFF_FE00, 0, 0);
        run_op("add_pos_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1, 0);
        chk("add_pos_ovf wrap result", wr_result, 32'h8000_0000);
        chk("add_pos_ovf wrap overflow", wr_overflow, 1);
        run_op("add_neg_ovf", 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 0);
        chk("add_neg_ovf wrap result", wr_result, 32'h7FFF_FFFF);

        run_op("mul", 3'd2, 32'h0000_0600, 32'h0000_0800, 33, 32'h0000_0C00, 0, 0);
        run_op("mul_neg_a", 3'd2, 32'hFFFF_FA00, 32'h0000_0800, 33, 32'hFFFF_F400, 0, 0);
        run_op("mul_neg_b", 3'd2, 32'h0000_0800, 32'hFFFF_FA00, 33, 32'hFFFF_F400, 0, 0);
        run_op("mul_neg_neg", 3'd2, 32'hFFFF_FA00, 32'hFFFF_F800, 33, 32'h0000_0C00, 0, 0);
        run_op("mul_round", 3'd2, 32'h0000_0001, 32'h0000_0200, 33, 32'h0000_0001, 0, 0);
        run_op("mul_ovf", 3'd2, 32'h7FFF_FFFF, 32'h0000_0800, 33, 32'h7FFF_FFFF, 1, 0);
        chk("mul_ovf wrap result", wr_result, 32'hFFFF_FFFE);
        chk("mul_ovf wrap overflow", wr_overflow, 1);

        run_op("div", 3'd3, 32'h0000_0C00, 32'h0000_0800, 43, 32'h0000_0600, 0, 0);
        run_op("div_neg", 3'd3, 32'hFFFF_F400, 32'h0000_0800, 43, 32'hFFFF_FA00, 0, 0);
        run_op("div_trunc_neg", 3'd3, 32'hFFFF_FC00, 32'h0000_0C00, 43, 32'hFFFF_FEAB, 0, 0);
        run_op("div_zero_pos", 3'd3, 32'h0000_0400, 32'h0000_0000, 43, 32'h7FFF_FFFF, 0, 1);
        chk("div_zero_pos wrap result", wr_result, 32'h7FFF_FFFF);
        chk("div_zero_pos wrap overflow", wr_overflow, 0);
        run_op("div_zero_neg", 3'd3, 32'hFFFF_FC00, 32'h0000_0000, 43, 32'h8000_0000, 0, 1);
        run_op("div_ovf", 3'd3, 32'h7FFF_FFFF, 32'h0000_0001, 43, 32'h7FFF_FFFF, 1, 0);
        chk("div_ovf wrap result", wr_result, 32'hFFFF_FC00);

        run_op("sqrt4", 3'd4, 32'h0000_1000, 32'h0000_0000, 22, 32'h0000_0800, 0, 0);
        run_op("sqrt2", 3'd4, 32'h0000_0800, 32'h1234_5678, 22, 32'h0000_05A8, 0, 0);
        run_op("sqrt0", 3'd4, 32'h0000_0000, 32'h0000_0000, 22, 32'h0000_0000, 0, 0);
        run_op("sqrt_neg", 3'd4, 32'hFFFF_F800, 32'h0000_0000, 22, 32'h0000_0000, 0, 1);

        run_op("bad_op5", 3'd5, 32'h0000_0600, 32'h0000_0800, 1, 32'h0000_0000, 0, 1);
        run_op("bad_op7", 3'd7, 32'h0000_0600, 32'h0000_0800, 1, 32'h0000_0000, 0, 1);

        // start pulsed mid-MUL with other operands must be ignored
        @(negedge clk);
        start = 1'b1; operation = 3'd2; operand_1 = 32'h0000_0600; operand_2 = 32'h0000_0800;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            if (cyc == 5) begin
                start = 1'b1; operation = 3'd0;
                operand_1 = 32'h0000_1234; operand_2 = 32'h0000_4321;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("mul_ignore latency", cyc, 33);
        chk("mul_ignore result", result, 32'h0000_0C00);

        // start in the DONE cycle is accepted back-to-back
        run_op("add_b2b_first", 3'd0, 32'h0000_0600, 32'h0000_0800, 1, 32'h0000_0E00, 0, 0);
        start = 1'b1; operation = 3'd1; operand_1 = 32'h0000_0800; operand_2 = 32'h0000_0600;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b busy", busy, 1);
        chk("b2b ready_low", ready, 0);
        @(posedge clk); #1;
        chk("b2b ready", ready, 1);
        chk("b2b result", result, 32'h0000_0200);

        // reset asserted mid-DIV aborts without a ready pulse
        @(negedge clk);
        start = 1'b1; operation = 3'd3; operand_1 = 32'h0000_0C00; operand_2 = 32'h0000_0800;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort ready", ready, 0);
        chk("abort result", result, 0);
        chk("abort flags", {overflow, invalid}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) seen_ready = 1'b1;
        end
        chk("abort no_ready", seen_ready, 0);
        run_op("add_after_abort", 3'd0, 32'h0000_0600, 32'h0000_0800, 1, 32'h0000_0E00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fixed_point_unit_seq.md
Name: fixed_point_unit_seq

Overview:
Parametrised, handshaked signed fixed-point arithmetic unit (two's complement, Q(WIDTH-FBITS).FBITS) for the execute stage.
Supports ADD, SUB, MUL, DIV and SQRT.
One op is in flight at a time: start/busy/ready handshake, deterministic per-op latency, optional saturation, status flags.
MUL, DIV and SQRT are multi-cycle iterative datapaths sharing one sequencer FSM.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 8.
FBITS, 10, fractional bits; 0 < FBITS < WIDTH; (WIDTH+FBITS) must be even.
SATURATE, 1, 1 = clamp overflowing results to max/min; 0 = wrap (truncate).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
start  input  1  request; sampled only when busy=0
operation  input  3  0=ADD 1=SUB 2=MUL 3=DIV 4=SQRT, 5-7 invalid
operand_1  input  WIDTH  signed fixed-point A (radicand for SQRT)
operand_2  input  WIDTH  signed fixed-point B (ignored for SQRT)
busy  output  1  op in progress; high from cycle after accepted start until the cycle ready pulses
result  output  WIDTH  fixed-point result; held until next accepted start
ready  output  1  one-cycle pulse, result/flags valid
overflow  output  1  result clamped/wrapped; valid with ready, held
invalid  output  1  div-by-zero, negative SQRT or bad opcode; valid with ready, held

Behaviour:
- Reset (reset=0, async): FSM to IDLE; busy=0, ready=0, result=0, overflow=0, invalid=0; aborts any op; no ready pulse for the aborted op.
- FSM states: IDLE, ADDSUB, MUL, DIV, SQRT, DONE.
- Accept: when start=1 and busy=0 at edge N, operands/opcode are latched and the FSM leaves IDLE.
- start while busy=1 is ignored; latched operands never change mid-op.
- Latency, from accept edge N to the edge where ready rises:
  - ADD/SUB: N+1.
  - MUL: N+WIDTH+1.
  - DIV: N+WIDTH+FBITS+1.
  - SQRT: N+(WIDTH+FBITS)/2+1.
  - Invalid opcode: N+1.
- ready is high exactly one cycle (DONE); busy drops in that same cycle. start in the DONE cycle is accepted (back-to-back allowed).
- ADD/SUB: computed at WIDTH+1 bits.
  - Overflow when the two top bits differ.
  - SATURATE=1 gives 0x7FF..F (positive) or 0x800..0 (negative); SATURATE=0 gives the low WIDTH bits.
- MUL: signed shift-add over WIDTH iterations, one bit per cycle, into a 2*WIDTH product.
  - Round half-up by adding bit FBITS-1, then take bits [WIDTH+FBITS-1:FBITS].
  - Overflow if bits above the taken field are not sign-extension of its MSB; saturate/wrap as ADD.
- DIV: magnitudes |A|<<FBITS / |B| by restoring division, one quotient bit per cycle, WIDTH+FBITS iterations.
  - Quotient is truncated toward zero; sign is applied at the end.
  - Overflow if the magnitude exceeds the range.
  - B=0: invalid=1, overflow=0, result = 0x7FF..F if A>=0 else 0x800..0, regardless of SATURATE; full latency still taken.
- SQRT: integer sqrt of A<<FBITS using the digit-by-digit (bit pair) method, (WIDTH+FBITS)/2 iterations, result truncated.
  - A<0: invalid=1, result=0, full latency.
  - A=0: result 0.
  - Never overflows.
- Invalid opcode: result=0, invalid=1, overflow=0.
- Flags are cleared at accept and updated only at DONE.

Test Plan:
- Reset, then ADD 0x600 (1.5) + 0x800 (2.0), start at edge N -> ready at N+1, result 0xE00, busy low, flags 0; SUB 0x600-0x800 -> 0xFFFFFE00 (-0.5).
- ADD 0x7FFFFFFF+0x00000001, SATURATE=1 -> 0x7FFFFFFF, overflow=1; SATURATE=0 -> 0x80000000, overflow=1.
- MUL 0x600*0x800 -> 0xC00 (3.0) at N+33; MUL 0xFFFFFA00 (-1.5)*0x800 -> 0xFFFFF400; MUL 0x7FFFFFFF*0x800 -> 0x7FFFFFFF, overflow=1.
- DIV 0xC00/0x800 -> 0x600 at N+43; DIV 0x400/0 -> 0x7FFFFFFF, invalid=1; SQRT 0x1000 (4.0) -> 0x800 at N+22; SQRT 0xFFFFF800 -> 0, invalid=1.
- Second start pulsed mid-MUL with different operands -> ignored, first result delivered unchanged; start in the DONE cycle -> accepted, busy=1 next cycle.
- Reset asserted mid-DIV (cycle N+10) -> busy/ready/result/flags 0 immediately; no ready after release; a fresh ADD completes normally.
